// File: rtl/xxhash_pkg.sv
// Shared XXH32 constants, rotate/avalanche helpers and the controller state encoding.
package xxhash_pkg;

    localparam logic [31:0] P1 = 32'd2654435761;
    localparam logic [31:0] P2 = 32'd2246822519;
    localparam logic [31:0] P3 = 32'd3266489917;
    localparam logic [31:0] P4 = 32'd668265263;
    localparam logic [31:0] P5 = 32'd374761393;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACCUM = 3'd1,
        FOLD  = 3'd2,
        WORDS = 3'd3,
        BYTES = 3'd4,
        AVAL  = 3'd5,
        DONE  = 3'd6
    } state_t;

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] r);
        return (x << r) | (x >> (6'd32 - {1'b0, r}));
    endfunction

    function automatic logic [31:0] avalanche(input logic [31:0] x);
        logic [31:0] h;
        h = x ^ (x >> 5'd15);
        h = h * P2;
        h = h ^ (h >> 5'd13);
        h = h * P3;
        h = h ^ (h >> 5'd16);
        return h;
    endfunction

endpackage

// File: rtl/xxhash32_round.sv
// One XXH32 accumulator lane step: rotl(lane + word*P2, 13) * P1.
module xxhash32_round
    import xxhash_pkg::*;
(
    input  logic [31:0] lane,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [31:0] acc_s;

    assign acc_s  = lane + word * P2;
    assign result = rotl(acc_s, 5'd13) * P1;

endmodule

// File: rtl/xxhash32_stream.sv
// Streaming XXH32 engine: absorbs 16-byte stripes at one beat per cycle, then folds
// the residual words and bytes serially and runs the avalanche before presenting the digest.
module xxhash32_stream
    import xxhash_pkg::*;
#(
    parameter int IN_WORDS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  seed_valid,
    input  logic [31:0]           seed,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*IN_WORDS-1:0] in_data,
    input  logic [4*IN_WORDS-1:0] in_keep,
    input  logic                  in_last,
    output logic                  hash_valid,
    input  logic                  hash_ready,
    output logic [31:0]           hash
);

    localparam int BEAT_BYTES = 4 * IN_WORDS;
    localparam int BEAT_BITS  = 32 * IN_WORDS;

    generate
        if (!(IN_WORDS == 1 || IN_WORDS == 2 || IN_WORDS == 4)) begin : g_bad_in_words
            $error("xxhash32_stream: IN_WORDS must be 1, 2 or 4");
        end
    endgenerate

    state_t         state_r;
    logic [31:0]    v_r [4];
    logic [31:0]    v_next_s [4];
    logic [31:0]    seed_r;
    logic [31:0]    length_r;
    logic [127:0]   buf_r;
    logic [4:0]     fill_r;
    logic [1:0]     n_w_r;
    logic [1:0]     n_b_r;
    logic [31:0]    h_r;
    logic           in_ready_r;
    logic           hash_valid_r;
    logic [31:0]    hash_r;

    logic [4:0]           pop_s;
    logic [BEAT_BITS-1:0] data_m_s;
    logic [127:0]         merged_s;
    logic [4:0]           fill_sum_s;
    logic                 stripe_full_s;
    logic [31:0]          fold_s;
    logic [31:0]          word_step_s;
    logic [31:0]          byte_step_s;

    // Count kept bytes and zero the unkept ones so they never pollute the buffer.
    always_comb begin
        pop_s    = 5'd0;
        data_m_s = {BEAT_BITS{1'b0}};
        for (int i = 0; i < BEAT_BYTES; i++) begin
            if (in_keep[i]) begin
                pop_s             = pop_s + 5'd1;
                data_m_s[8*i +: 8] = in_data[8*i +: 8];
            end else begin
                data_m_s[8*i +: 8] = 8'd0;
            end
        end
    end

    // Buffer fill is always beat-aligned before a beat, so a beat never straddles a stripe.
    assign merged_s      = buf_r | (128'(data_m_s) << {fill_r, 3'b000});
    assign fill_sum_s    = fill_r + pop_s;
    assign stripe_full_s = (fill_sum_s == 5'd16);

    generate
        for (genvar k = 0; k < 4; k++) begin : g_lane
            xxhash32_round u_round (
                .lane   (v_r[k]),
                .word   (merged_s[32*k +: 32]),
                .result (v_next_s[k])
            );
        end
    endgenerate

    assign fold_s = ((length_r >= 32'd16)
                     ? (rotl(v_r[0], 5'd1) + rotl(v_r[1], 5'd7) + rotl(v_r[2], 5'd12) + rotl(v_r[3], 5'd18))
                     : (seed_r + P5)) + length_r;
    assign word_step_s = rotl(h_r + buf_r[31:0] * P3, 5'd17) * P4;
    assign byte_step_s = rotl(h_r + {24'd0, buf_r[7:0]} * P5, 5'd11) * P1;

    // Controller FSM with all datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            for (int i = 0; i < 4; i++) v_r[i] <= 32'd0;
            seed_r       <= 32'd0;
            length_r     <= 32'd0;
            buf_r        <= 128'd0;
            fill_r       <= 5'd0;
            n_w_r        <= 2'd0;
            n_b_r        <= 2'd0;
            h_r          <= 32'd0;
            in_ready_r   <= 1'b0;
            hash_valid_r <= 1'b0;
            hash_r       <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (seed_valid) begin
                        v_r[0]     <= seed + P1 + P2;
                        v_r[1]     <= seed + P2;
                        v_r[2]     <= seed;
                        v_r[3]     <= seed - P1;
                        seed_r     <= seed;
                        length_r   <= 32'd0;
                        buf_r      <= 128'd0;
                        fill_r     <= 5'd0;
                        in_ready_r <= 1'b1;
                        state_r    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid && in_ready_r) begin
                        length_r <= length_r + 32'(pop_s);
                        if (stripe_full_s) begin
                            for (int i = 0; i < 4; i++) v_r[i] <= v_next_s[i];
                            buf_r  <= 128'd0;
                            fill_r <= 5'd0;
                        end else begin
                            buf_r  <= merged_s;
                            fill_r <= fill_sum_s;
                        end
                        if (in_last) begin
                            // A full stripe leaves fill_sum=16, whose low nibble yields n_w=n_b=0.
                            n_w_r      <= fill_sum_s[3:2];
                            n_b_r      <= fill_sum_s[1:0];
                            in_ready_r <= 1'b0;
                            state_r    <= FOLD;
                        end
                    end
                end
                FOLD: begin
                    h_r <= fold_s;
                    if (n_w_r != 2'd0) begin
                        state_r <= WORDS;
                    end else if (n_b_r != 2'd0) begin
                        state_r <= BYTES;
                    end else begin
                        state_r <= AVAL;
                    end
                end
                WORDS: begin
                    h_r   <= word_step_s;
                    buf_r <= buf_r >> 7'd32;
                    n_w_r <= n_w_r - 2'd1;
                    if (n_w_r == 2'd1) begin
                        state_r <= (n_b_r != 2'd0) ? BYTES : AVAL;
                    end
                end
                BYTES: begin
                    h_r   <= byte_step_s;
                    buf_r <= buf_r >> 7'd8;
                    n_b_r <= n_b_r - 2'd1;
                    if (n_b_r == 2'd1) begin
                        state_r <= AVAL;
                    end
                end
                AVAL: begin
                    hash_r       <= avalanche(h_r);
                    hash_valid_r <= 1'b1;
                    state_r      <= DONE;
                end
                DONE: begin
                    if (hash_ready) begin
                        hash_valid_r <= 1'b0;
                        state_r      <= IDLE;
                    end
                end
                default: begin
                    in_ready_r   <= 1'b0;
                    hash_valid_r <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign hash_valid = hash_valid_r;
    assign hash       = hash_r;

endmodule
